data_mem_responder: RTL

- Responder end of the per-thread LSU data-memory handshake. Serves NUM_CONSUMERS LSU read/write request ports against an internal data memory of 2^ADDR_BITS x DATA_BITS.
- Services one request at a time. Consumers are granted round-robin and each access takes a fixed LATENCY.
- Sits between the cores' LSUs and data memory. Used as the data-memory model in core and GPU benches, and as the on-chip data store.

---
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Responder side of the LSU data-memory handshake: round-robin arbitration over
// NUM_CONSUMERS read/write ports, one fixed-latency access at a time.
module data_mem_responder #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int LATENCY       = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    input  logic                               mem_init_en,
    input  logic [ADDR_BITS-1:0]               mem_init_addr,
    input  logic [DATA_BITS-1:0]               mem_init_data,
    input  logic [ADDR_BITS-1:0]               debug_addr,
    output logic [DATA_BITS-1:0]               debug_data,
    output logic                               busy
);

    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    state_t                           state, next_state;
    logic [IDX_W-1:0]                 rr_ptr, idx, grant_idx, cand;
    logic                             grant, grant_read, do_access, release_port;
    logic                             op_read;
    logic [ADDR_BITS-1:0]             addr, grant_addr;
    logic [DATA_BITS-1:0]             wdata, grant_wdata;
    logic [CNT_W-1:0]                 counter;
    logic [NUM_CONSUMERS-1:0]         requesting, read_ready_q, write_ready_q;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q;
    logic [DATA_BITS-1:0]             mem [2**ADDR_BITS];

    assign requesting = consumer_read_valid | consumer_write_valid;

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_CONSUMERS);
            if (requesting[cand]) begin
                grant     = 1'b1;
                grant_idx = cand;
            end
        end
        grant_read  = consumer_read_valid[grant_idx];
        grant_addr  = grant_read ? consumer_read_address[grant_idx*ADDR_BITS +: ADDR_BITS]
                                 : consumer_write_address[grant_idx*ADDR_BITS +: ADDR_BITS];
        grant_wdata = consumer_write_data[grant_idx*DATA_BITS +: DATA_BITS];
    end

    always_comb begin
        next_state   = state;
        do_access    = 1'b0;
        release_port = 1'b0;
        case (state)
            IDLE: begin
                if (grant) next_state = BUSY;
            end
            BUSY: begin
                if (counter == '0) begin
                    do_access  = 1'b1;
                    next_state = RESPOND;
                end
            end
            RESPOND: begin
                if (op_read ? !consumer_read_valid[idx] : !consumer_write_valid[idx]) begin
                    release_port = 1'b1;
                    next_state   = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            idx           <= '0;
            op_read       <= 1'b0;
            addr          <= '0;
            wdata         <= '0;
            counter       <= '0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            read_data_q   <= '0;
        end else begin
            if (state == IDLE && grant) begin
                idx     <= grant_idx;
                op_read <= grant_read;
                addr    <= grant_addr;
                wdata   <= grant_wdata;
                counter <= CNT_W'(LATENCY - 1);
            end
            if (state == BUSY && counter != '0) counter <= counter - 1'b1;
            if (do_access) begin
                if (op_read) begin
                    read_data_q[idx*DATA_BITS +: DATA_BITS] <= mem[addr];
                    read_ready_q[idx] <= 1'b1;
                end else begin
                    write_ready_q[idx] <= 1'b1;
                end
            end
            if (release_port) begin
                read_ready_q[idx]  <= 1'b0;
                write_ready_q[idx] <= 1'b0;
                rr_ptr <= (idx == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    // Backdoor preload runs regardless of state; a completing store is written last so it wins.
    always_ff @(posedge clk) begin
        if (mem_init_en) mem[mem_init_addr] <= mem_init_data;
        if (!reset && do_access && !op_read) mem[addr] <= wdata;
    end

    assign consumer_read_ready  = read_ready_q;
    assign consumer_write_ready = write_ready_q;
    assign consumer_read_data   = read_data_q;
    assign debug_data           = mem[debug_addr];
    assign busy                 = (state != IDLE);

endmodule
